fifo_rd_fwft: RTL and testbench

- Read-side adapter placed directly downstream of the asynchronous FIFO, in the read clock domain.
- Converts the FIFO's standard read interface (rinc/rempty/rdata, data one cycle after an accepted rinc) into a first-word-fall-through valid/ready stream for downstream consumers.
- Holds up to 2 words in an internal buffer so a continuously ready consumer gets one word per cycle.

---
 rtl/fifo_rd_fwft.sv | 106 ++++++++++
 tb/tb_fifo_rd_fwft.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: read-side first-word-fall-through adapter for the async FIFO.
// It turns the FIFO's rinc/rempty/rdata read port, where data arrives one
// cycle after the request, into a valid/ready stream. A 2-entry buffer lets a
// consumer that is always ready take one word per cycle.
// Optional build macro: FWFT_LEVEL_EN adds the registered `level` output,
// which carries the buffer occupancy (0..2).
module fifo_rd_fwft #(
    parameter int WIDTH = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             fifo_rempty,
    output logic             fifo_rinc,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FWFT_LEVEL_EN
   ,output logic [1:0]       level
`endif
);

    // The state value is the number of buffered words.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             inflight;
    logic             push, pop;
    logic [2:0]       occ;
    logic [WIDTH-1:0] entry0, entry1, entry0_nxt, entry1_nxt;

    // A word requested last cycle is on fifo_rdata now and is captured this cycle.
    assign push = inflight;
    // Decode pop from state instead of from m_valid so no comb loop forms through the output block.
    assign pop  = (state != EMPTY) & m_ready;

    // State register, in-flight flag and buffer storage
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state    <= EMPTY;
            inflight <= 1'b0;
            entry0   <= '0;
            entry1   <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rinc;
            entry0   <= entry0_nxt;
            entry1   <= entry1_nxt;
        end
    end

    // Next state and buffer movement for each push/pop combination
    always_comb begin
        state_nxt  = state;
        entry0_nxt = entry0;
        entry1_nxt = entry1;
        case ({push, pop})
            2'b10: begin
                if (state == EMPTY) begin
                    entry0_nxt = fifo_rdata;
                    state_nxt  = ONE;
                end else begin
                    entry1_nxt = fifo_rdata;
                    state_nxt  = TWO;
                end
            end
            2'b01: begin
                entry0_nxt = entry1;
                state_nxt  = (state == TWO) ? ONE : EMPTY;
            end
            2'b11: begin
                if (state == TWO) begin
                    entry0_nxt = entry1;
                    entry1_nxt = fifo_rdata;
                end else begin
                    entry0_nxt = fifo_rdata;
                end
            end
            default: ;
        endcase
    end

    // Stream outputs and the read request. Request only when the words held
    // plus the word in flight, minus the word leaving this cycle, stay below 2.
    always_comb begin
        m_valid   = (state != EMPTY);
        m_data    = entry0;
        occ       = {1'b0, state} + {2'b00, inflight};
        fifo_rinc = !rrst && !fifo_rempty && (occ < (3'd2 + {2'b00, pop}));
    end

`ifdef FWFT_LEVEL_EN
    // Occupancy output, registered alongside the state
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) level <= 2'd0;
        else      level <= state_nxt;
    end
`endif

`ifndef SYNTHESIS
    // The request rule must make it impossible to push while full without popping.
    a_no_overflow: assert property (@(posedge rclk) disable iff (rrst)
        !(push && !pop && state == TWO));
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: scoreboard bench for fifo_rd_fwft. A queue models the FIFO.
// Every word written into the model FIFO is pushed to the scoreboard, and it
// is popped and compared when the stream handshake accepts a word.
module tb_fifo_rd_fwft;
    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       fifo_rempty = 1'b1;
    logic       fifo_rinc;
    logic [7:0] fifo_rdata = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef FWFT_LEVEL_EN
    logic [1:0] level;
`endif

    fifo_rd_fwft #(.WIDTH(8)) dut (
        .rclk(rclk), .rrst(rrst),
        .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc), .fifo_rdata(fifo_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FWFT_LEVEL_EN
       ,.level(level)
`endif
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad   = 0;

    logic [7:0] fq[$];   // model FIFO contents
    logic [7:0] sb[$];   // expected stream order
    logic [7:0] nxt_word = 8'h00;
    logic       rinc_prev = 1'b0, pop_prev = 1'b0, infl = 1'b0;
    logic       prev_v = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int         mcnt = 0;
    int         cyc = 0, n_rinc = 0, n_acc = 0, first_acc = -1, last_acc = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic put(input logic [7:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    // One clock cycle. Inputs change on the falling edge. Observations taken
    // 1 time unit later describe what the next rising edge will sample.
    task automatic cycle(input logic rdy, input logic fe);
        @(negedge rclk);
        cyc++;
        // apply what the last rising edge did to the occupancy model
        mcnt = mcnt + int'(infl) - int'(pop_prev);
        infl = rinc_prev;
        if (rrst) begin mcnt = 0; infl = 1'b0; end
        if (rinc_prev) fifo_rdata = nxt_word;
        m_ready     = rdy;
        fifo_rempty = fe | (fq.size() == 0);
        #1;
        chk("valid", m_valid, (mcnt != 0));
`ifdef FWFT_LEVEL_EN
        chk("level", level, mcnt);
`endif
        if (prev_v && !prev_rdy) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, prev_d);
        end
        if (fifo_rempty) chk("rinc_empty", fifo_rinc, 0);
        chk("occ_le2", (mcnt + int'(infl)) <= 2, 1);
        rinc_prev = fifo_rinc;
        if (fifo_rinc) begin
            n_rinc++;
            if (fq.size() != 0) nxt_word = fq.pop_front();
        end
        pop_prev = m_valid & m_ready;
        if (pop_prev) begin
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("data", m_data, sb.pop_front());
        end
        prev_v   = m_valid;
        prev_rdy = m_ready;
        prev_d   = m_data;
    endtask

    task automatic clr_model();
        fq.delete(); sb.delete();
        rinc_prev = 1'b0; pop_prev = 1'b0; infl = 1'b0; mcnt = 0;
        prev_v = 1'b0; prev_rdy = 1'b0;
    endtask

    initial begin
        int base_r, base_a, pushed, budget;
        logic [7:0] w;

        // reset state
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_rinc", fifo_rinc, 0);
        chk("rst_data", m_data, 8'h00);
`ifdef FWFT_LEVEL_EN
        chk("rst_level", level, 0);
`endif
        cycle(0, 0); cycle(0, 0);
        rrst = 1'b0;
        cycle(0, 0);

        // fill latency: empty falls in this cycle, data reaches the stream two cycles later
        put(8'hA5);
        cycle(0, 0);
        chk("fill_rinc", fifo_rinc, 1);
        cycle(0, 0);
        chk("fill_v1", m_valid, 0);
        cycle(1, 0);
        chk("fill_v2", m_valid, 1);
        chk("fill_d", m_data, 8'hA5);
        cycle(1, 0);
        chk("fill_drained", m_valid, 0);

        // streaming 0x01..0x10 with a consumer that is always ready
        for (int i = 1; i <= 16; i++) put(8'(i));
        base_r = n_rinc; base_a = n_acc; first_acc = -1;
        for (int i = 0; i < 24; i++) cycle(1, 0);
        chk("strm_count", n_acc - base_a, 16);
        chk("strm_nogap", last_acc - first_acc, 15);
        chk("strm_rinc", n_rinc - base_r, 16);
        chk("strm_end_valid", m_valid, 0);

        // backpressure: three words, consumer stalled for 10 cycles
        put(8'h11); put(8'h22); put(8'h33);
        base_r = n_rinc; base_a = n_acc;
        for (int i = 0; i < 10; i++) cycle(0, 0);
        chk("bp_rinc", n_rinc - base_r, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 8'h11);
        for (int i = 0; i < 6; i++) cycle(1, 0);
        chk("bp_count", n_acc - base_a, 3);
        chk("bp_sb_empty", sb.size(), 0);

        // asynchronous reset mid-cycle while the buffer is full
        put(8'h44); put(8'h55); put(8'h66);
        for (int i = 0; i < 5; i++) cycle(0, 0);
        chk("prerst_valid", m_valid, 1);
        #2 rrst = 1'b1;
        #1;
        chk("mrst_valid", m_valid, 0);
        chk("mrst_rinc", fifo_rinc, 0);
`ifdef FWFT_LEVEL_EN
        chk("mrst_level", level, 0);
`endif
        clr_model();
        cycle(0, 0); cycle(0, 0);
        rrst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 0);
        chk("postrst_valid", m_valid, 0);

        // random stalls and random empty gaps over 10,000 words
        base_a = n_acc; pushed = 0; budget = 0;
        while ((n_acc - base_a) < 10000 && budget < 60000) begin
            if (pushed < 10000 && $urandom_range(99) < 60) begin
                w = 8'($urandom);
                put(w);
                pushed++;
            end
            cycle(1'($urandom_range(1)), ($urandom_range(99) < 25));
            budget++;
        end
        chk("rand_count", n_acc - base_a, 10000);
        chk("rand_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
